// File: rtl/note_sequencer.sv
// Step sequencer for the synth voice: plays a programmable pattern of oscillator
// count values and produces the one-cycle ADSR trigger and the note gate.
`timescale 1ns/1ps
module note_sequencer #(
  parameter int STEPS  = 8,
  parameter int TICK_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [31:0]              wr_count,
  input  logic                     wr_rest,
  input  logic [$clog2(STEPS):0]   num_steps,
  input  logic [TICK_W-1:0]        step_len,
  input  logic [TICK_W-1:0]        gate_len,
  input  logic                     run,
  input  logic                     pause,
  output logic [31:0]              osc_count,
  output logic                     trig,
  output logic                     gate,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     playing,
  output logic [1:0]               dbg_state
);
  localparam int AW = $clog2(STEPS);
  localparam logic [AW:0]       N_MAX = (AW+1)'(STEPS);
  localparam logic [AW:0]       N_ONE = (AW+1)'(1);
  localparam logic [TICK_W-1:0] T_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] T_TWO = TICK_W'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2} state_e;

  state_e            state_q;
  logic [31:0]       count_q [STEPS];
  logic [STEPS-1:0]  rest_q;
  logic [AW-1:0]     step_idx_q;
  logic [TICK_W-1:0] tick_q, sl_q, gl_q;
  logic [31:0]       osc_count_q;
  logic              trig_q, gate_q, cur_rest_q;

  logic [AW:0]       n_d, next_idx_d;
  logic [AW-1:0]     start_idx_d;
  logic [TICK_W-1:0] sl_d, gl_d, tick_inc_d;
  logic              last_tick_d, step_start_d, start_rest_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) count_q[i] <= '0;
      rest_q <= '1;
    end else if (wr_en) begin
      count_q[wr_addr] <= wr_count;
      rest_q[wr_addr]  <= wr_rest;
    end
  end

  // Lengths and pattern length are sampled live and only take effect at a step start.
  always_comb begin
    n_d = num_steps;
    if (num_steps == '0) n_d = N_ONE;
    else if (num_steps > N_MAX) n_d = N_MAX;
    next_idx_d = {1'b0, step_idx_q} + N_ONE;
    if (next_idx_d >= n_d) next_idx_d = '0;
    start_idx_d  = (state_q == IDLE) ? '0 : next_idx_d[AW-1:0];
    start_rest_d = rest_q[start_idx_d];
    sl_d         = (step_len < T_TWO) ? T_TWO : step_len;
    gl_d         = (gate_len > sl_d - T_ONE) ? sl_d - T_ONE : gate_len;
    tick_inc_d   = tick_q + T_ONE;
    last_tick_d  = (tick_q == sl_q - T_ONE);
    step_start_d = run && !pause && ((state_q == IDLE) || last_tick_d);
  end

  // A resume from HOLD acts as the PLAY edge that the pause swallowed, so a
  // pause on the boundary cycle defers the step start to the resume edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_idx_q  <= '0;
      tick_q      <= '0;
      sl_q        <= T_TWO;
      gl_q        <= '0;
      osc_count_q <= '0;
      trig_q      <= 1'b0;
      gate_q      <= 1'b0;
      cur_rest_q  <= 1'b1;
    end else begin
      trig_q <= 1'b0;
      if (!run) begin
        state_q    <= IDLE;
        step_idx_q <= '0;
        tick_q     <= '0;
        gate_q     <= 1'b0;
      end else if (step_start_d) begin
        state_q    <= PLAY;
        step_idx_q <= start_idx_d;
        tick_q     <= '0;
        sl_q       <= sl_d;
        gl_q       <= gl_d;
        cur_rest_q <= start_rest_d;
        if (!start_rest_d) begin
          osc_count_q <= count_q[start_idx_d];
          trig_q      <= 1'b1;
          gate_q      <= (gl_d != '0);
        end else begin
          gate_q <= 1'b0;
        end
      end else begin
        case (state_q)
          PLAY: begin
            if (pause) begin
              state_q <= HOLD;
              gate_q  <= 1'b0;
            end else begin
              tick_q <= tick_inc_d;
              if (tick_inc_d == gl_q) gate_q <= 1'b0;
            end
          end
          HOLD: begin
            if (!pause) begin
              state_q <= PLAY;
              tick_q  <= tick_inc_d;
              gate_q  <= (tick_inc_d < gl_q) && !cur_rest_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign osc_count = osc_count_q;
  assign trig      = trig_q;
  assign gate      = gate_q;
  assign step_idx  = step_idx_q;
  assign playing   = (state_q != IDLE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a position-based reference of the pattern
// predicts trig/gate/osc_count/step_idx every cycle, plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_note_sequencer;
  localparam int STEPS  = 8;
  localparam int TICK_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [31:0]       wr_count;
  logic              wr_rest;
  logic [3:0]        num_steps;
  logic [TICK_W-1:0] step_len, gate_len;
  logic              run, pause;
  logic [31:0]       osc_count;
  logic              trig, gate, playing;
  logic [2:0]        step_idx;
  logic [1:0]        dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  string       sect    = "init";
  logic [31:0] exp_cnt [STEPS];
  logic        exp_rest [STEPS];
  int          m_pos;
  logic [31:0] m_osc;

  note_sequencer #(.STEPS(STEPS), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_count(wr_count),
    .wr_rest(wr_rest), .num_steps(num_steps), .step_len(step_len), .gate_len(gate_len),
    .run(run), .pause(pause), .osc_count(osc_count), .trig(trig), .gate(gate),
    .step_idx(step_idx), .playing(playing), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d expected %0d", sect, tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) begin
      exp_cnt[i]  = '0;
      exp_rest[i] = 1'b1;
    end
    m_osc = '0;
  endtask

  task automatic write_entry(input int addr, input int cnt, input bit rest);
    wr_en    = 1'b1;
    wr_addr  = 3'(addr);
    wr_count = 32'(cnt);
    wr_rest  = rest;
    step_clk();
    wr_en = 1'b0;
    exp_cnt[addr]  = 32'(cnt);
    exp_rest[addr] = rest;
  endtask

  task automatic start_run(input int n, input int sl, input int gl);
    num_steps = 4'(n);
    step_len  = TICK_W'(sl);
    gate_len  = TICK_W'(gl);
    run       = 1'b1;
    m_pos     = -1;
  endtask

  task automatic stop_run();
    run = 1'b0;
    step_clk();
    check("stop.playing", playing, 0);
    check("stop.gate", gate, 0);
    check("stop.trig", trig, 0);
    check("stop.step_idx", step_idx, 0);
    check("stop.osc_hold", osc_count, m_osc);
  endtask

  // sl/gl/n are the effective (clamped) values; pause is held on edges p_at+1..p_at+p_len.
  task automatic play(input int ncyc, input int sl, input int gl, input int n,
                      input int p_at, input int p_len);
    int tk, s;
    bit held;
    for (int c = 1; c <= ncyc; c++) begin
      held  = (c > p_at) && (c <= p_at + p_len);
      pause = held;
      step_clk();
      if (!held) m_pos++;
      tk = m_pos % sl;
      s  = (m_pos / sl) % n;
      if (!held && tk == 0 && !exp_rest[s]) m_osc = exp_cnt[s];
      check("trig", trig, 32'(!held && tk == 0 && !exp_rest[s]));
      check("gate", gate, 32'(!held && tk < gl && !exp_rest[s]));
      check("step_idx", step_idx, s);
      check("osc_count", osc_count, m_osc);
      check("playing", playing, 1);
    end
    pause = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_count = '0; wr_rest = 1'b0;
    num_steps = 4'd4; step_len = 24'd10; gate_len = 24'd4; run = 1'b0; pause = 1'b0;
    model_reset();
    step_clk();
    step_clk();
    sect = "reset";
    check("osc_count", osc_count, 0);
    check("trig", trig, 0);
    check("gate", gate, 0);
    check("step_idx", step_idx, 0);
    check("playing", playing, 0);
    rst = 1'b0;
    step_clk();

    sect = "basic";
    write_entry(0, 100, 0);
    write_entry(1, 200, 0);
    write_entry(2, 300, 0);
    write_entry(3, 400, 0);
    start_run(4, 10, 4);
    play(45, 10, 4, 4, 0, 0);

    sect = "reset_mid_play";
    rst = 1'b1;
    run = 1'b0;
    #1;
    check("gate", gate, 0);
    check("trig", trig, 0);
    check("osc_count", osc_count, 0);
    check("step_idx", step_idx, 0);
    check("playing", playing, 0);
    step_clk();
    rst = 1'b0;
    model_reset();
    step_clk();

    sect = "rests_only";
    start_run(4, 3, 1);
    play(20, 3, 1, 4, 0, 0);
    stop_run();

    sect = "rest_entry";
    write_entry(0, 100, 0);
    write_entry(1, 200, 1);
    write_entry(2, 300, 0);
    write_entry(3, 400, 0);
    start_run(4, 10, 4);
    play(40, 10, 4, 4, 0, 0);
    stop_run();

    sect = "step_len_0";
    start_run(4, 0, 4);
    play(16, 2, 1, 4, 0, 0);
    stop_run();

    sect = "gate_clamp";
    write_entry(1, 200, 0);
    start_run(4, 10, 50);
    play(20, 10, 9, 4, 0, 0);
    stop_run();

    sect = "pause_mid";
    start_run(4, 10, 4);
    play(40, 10, 4, 4, 3, 5);
    sect = "pause_boundary";
    play(12, 10, 4, 4, 5, 3);
    play(6, 10, 4, 4, 0, 0);

    sect = "stop_priority";
    run   = 1'b0;
    pause = 1'b1;
    step_clk();
    check("playing", playing, 0);
    check("step_idx", step_idx, 0);
    check("trig", trig, 0);
    check("gate", gate, 0);
    pause = 1'b0;
    start_run(4, 10, 4);
    play(3, 10, 4, 4, 0, 0);

    sect = "write_playing";
    play(21, 10, 4, 4, 0, 0);
    wr_en = 1'b1; wr_addr = 3'd2; wr_count = 32'd999; wr_rest = 1'b0;
    step_clk();
    wr_en = 1'b0;
    m_pos++;
    check("osc_keep", osc_count, 300);
    check("step_idx", step_idx, 2);
    play(6, 10, 4, 4, 0, 0);
    exp_cnt[2]  = 32'd999;
    exp_rest[2] = 1'b0;
    play(9, 10, 4, 4, 0, 0);

    sect = "shrink_n";
    num_steps = 4'd2;
    step_clk();
    check("step_idx", step_idx, 0);
    check("trig", trig, 1);
    check("osc_count", osc_count, 100);
    num_steps = 4'd4;
    m_pos = 0;
    m_osc = 32'd100;
    sect = "new_value_pass";
    play(25, 10, 4, 4, 0, 0);
    check("osc_new", osc_count, 999);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
